// File: rtl/dmem_responder_if.sv
// Request/response bundle between the data-cache controller (master) and the
// memory responder (slave).
interface dmem_responder_if #(
  parameter int LINE_WORDS = 4
) ();
  logic                       memory_valid;
  logic                       memory_for_store;
  logic [31:0]                memory_addr;
  logic [31:0]                memory_wdata;
  logic [3:0]                 memory_wstrb;
  logic                       memory_ready;
  logic [32*LINE_WORDS-1:0]   memory_rdata;
  logic                       proto_err;

  modport master (
    output memory_valid, memory_for_store, memory_addr, memory_wdata, memory_wstrb,
    input  memory_ready, memory_rdata, proto_err
  );

  modport slave (
    input  memory_valid, memory_for_store, memory_addr, memory_wdata, memory_wstrb,
    output memory_ready, memory_rdata, proto_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-cache memory responder: line fills and byte-strobed write-through stores
// with a fixed access latency. Define DMEM_PROTOCOL_CHECK_EN for the sticky proto_err monitor.
module dmem_responder #(
  parameter int LINE_WORDS  = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave mem_if
);
  localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BEAT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LINE_SH = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [3:0]        WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit                HAS_WAIT  = (LATENCY > 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [IDX_W-1:0]            widx_q;
  logic                        store_q;
  logic [31:0]                 wdata_q;
  logic [3:0]                  wstrb_q;
  logic [LINE_WORDS-1:0][31:0] line_q;
  logic [31:0]                 mem_q [DEPTH_WORDS];

  logic             accept;
  logic [IDX_W-1:0] base_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [31:0]      rd_word;
  logic [31:0]      old_word;
  logic [31:0]      merged_word;

  assign accept = (state_q == S_IDLE) && mem_if.memory_valid;

  // Only the low IDX_W word-address bits are kept, so every index wraps modulo depth.
  assign base_idx = (widx_q >> LINE_SH) << LINE_SH;
  assign fill_idx = base_idx + IDX_W'(beat_q);
  assign rd_word  = mem_q[fill_idx];
  assign old_word = mem_q[widx_q];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = wstrb_q[gi] ? wdata_q[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (mem_if.memory_valid) begin
          beat_d = '0;
          if (HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = mem_if.memory_for_store ? S_WR : S_FILL;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = store_q ? S_WR : S_FILL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_FILL: begin
        if (beat_q == LAST_BEAT) state_d = S_RESP;
        else                     beat_d  = beat_q + 1'b1;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      widx_q  <= '0;
      store_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      if (accept) begin
        widx_q  <= mem_if.memory_addr[IDX_W+1:2];
        store_q <= mem_if.memory_for_store;
        wdata_q <= mem_if.memory_wdata;
        wstrb_q <= mem_if.memory_wstrb;
      end
    end
  end

  // Line buffer changes only on fill beats; stores leave the last line visible.
  always_ff @(posedge clk) begin
    if (!rst_n)                  line_q         <= '0;
    else if (state_q == S_FILL)  line_q[beat_q] <= rd_word;
  end

  // Array has no reset; a reset coinciding with WR suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == S_WR)) mem_q[widx_q] <= merged_word;
  end

  assign mem_if.memory_ready = (state_q == S_RESP);
  assign mem_if.memory_rdata = line_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic [31:0] addr_chk_q;
  logic        busy;
  logic        viol;
  logic        proto_err_q;

  assign busy = (state_q == S_WAIT) || (state_q == S_FILL) || (state_q == S_WR);
  assign viol = busy && (!mem_if.memory_valid
                         || (mem_if.memory_addr != addr_chk_q)
                         || (mem_if.memory_for_store != store_q)
                         || (mem_if.memory_wdata != wdata_q)
                         || (mem_if.memory_wstrb != wstrb_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_chk_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) addr_chk_q  <= mem_if.memory_addr;
      if (viol)   proto_err_q <= 1'b1;
    end
  end

  assign mem_if.proto_err = proto_err_q;
`else
  assign mem_if.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: a default-configured instance and
// a LATENCY=0 / DEPTH_WORDS=16 instance for address-wrap checks.
module tb_dmem_responder;
  localparam int LAT_A = 3;
  localparam int DEP_A = 1024;
  localparam int LAT_B = 0;
  localparam int DEP_B = 16;

  typedef struct packed {
    logic [127:0] rdata;
    logic [7:0]   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  exp_t         sb_q[$];
  logic [31:0]  model_a [DEP_A];
  logic [31:0]  model_b [DEP_B];
  logic [127:0] last_a;
  logic [127:0] last_b;

  always #5 clk = ~clk;

  dmem_responder_if #(.LINE_WORDS(4)) a_if ();
  dmem_responder_if #(.LINE_WORDS(4)) b_if ();

  dmem_responder #(.LINE_WORDS(4), .DEPTH_WORDS(DEP_A), .LATENCY(LAT_A)) u_a (
    .clk(clk), .rst_n(rst_n), .mem_if(a_if)
  );
  dmem_responder #(.LINE_WORDS(4), .DEPTH_WORDS(DEP_B), .LATENCY(LAT_B)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_if(b_if)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input bit st, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb);
    if (sel) begin
      b_if.memory_valid = v; b_if.memory_for_store = st; b_if.memory_addr = addr;
      b_if.memory_wdata = wd; b_if.memory_wstrb = strb;
    end else begin
      a_if.memory_valid = v; a_if.memory_for_store = st; a_if.memory_addr = addr;
      a_if.memory_wdata = wd; a_if.memory_wstrb = strb;
    end
  endtask

  // Expected line for a load, built from the bench's own word model with wrap.
  function automatic logic [127:0] model_line(input bit sel, input logic [31:0] addr);
    logic [127:0] line;
    logic [31:0]  base;
    base = (addr >> 2) & ~32'd3;
    for (int w = 0; w < 4; w++) begin
      if (sel) line[32*w +: 32] = model_b[(base + w) % DEP_B];
      else     line[32*w +: 32] = model_a[(base + w) % DEP_A];
    end
    return line;
  endfunction

  // One request: push expectation, assert valid in the current (IDLE) cycle,
  // wait for ready, pop and compare. n counts edges from the accept edge, so
  // ready seen after edge n is the spec's cycle t+n.
  task automatic do_req(input bit sel, input bit st, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb);
    exp_t        e;
    int          n;
    bit          seen;
    int          lat;
    logic [31:0] idx;
    lat = sel ? LAT_B : LAT_A;
    if (st) begin
      idx = (addr >> 2) % (sel ? DEP_B : DEP_A);
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          if (sel) model_b[idx][8*b +: 8] = wd[8*b +: 8];
          else     model_a[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
      e.rdata = sel ? last_b : last_a;
      e.lat   = 8'(2 + lat);
    end else begin
      e.rdata = model_line(sel, addr);
      e.lat   = 8'(1 + lat + 4);
      if (sel) last_b = e.rdata; else last_a = e.rdata;
    end
    sb_q.push_back(e);
    drive(sel, 1'b1, st, addr, wd, strb);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      seen = sel ? b_if.memory_ready : a_if.memory_ready;
    end
    e = sb_q.pop_front();
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk(st ? "store_ready_seen" : "load_ready_seen", {127'd0, seen}, 128'd1);
    chk(st ? "store_latency" : "load_latency", n, {120'd0, e.lat});
    chk(st ? "store_rdata_kept" : "load_rdata", sel ? b_if.memory_rdata : a_if.memory_rdata, e.rdata);
    $display("txn %s %s addr=%08h n=%0d rdata=%032h", sel ? "B" : "A", st ? "ST" : "LD",
             addr, n, sel ? b_if.memory_rdata : a_if.memory_rdata);
    @(posedge clk); #1;
    chk("no_dup_ready", sel ? b_if.memory_ready : a_if.memory_ready, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   pulses;
    int   n;
    logic exp_perr;
`ifdef DMEM_PROTOCOL_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    last_a = '0;
    last_b = '0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ready_a", a_if.memory_ready, 128'd0);
    chk("reset_rdata_a", a_if.memory_rdata, 128'd0);
    chk("reset_perr_a", a_if.proto_err, 128'd0);
    chk("reset_ready_b", b_if.memory_ready, 128'd0);
    chk("reset_rdata_b", b_if.memory_rdata, 128'd0);

    // Preload words 4..7 then the basic line load.
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 32'h10 + 4 * i, 32'hA0 + i, 4'hF);
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    chk("first_line_const", a_if.memory_rdata, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("first_perr", a_if.proto_err, 128'd0);

    // Byte-strobed store over an all-ones word, then read it back.
    do_req(1'b0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF);
    do_req(1'b0, 1'b1, 32'h16, 32'h1122_3344, 4'b0101);
    do_req(1'b0, 1'b0, 32'h0000_001C, 32'h0, 4'h0);
    chk("strobe_word1_const", a_if.memory_rdata[63:32], 32'hFF22_FF44);

    // Other addresses and a line elsewhere in the array.
    do_req(1'b0, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'hF);
    do_req(1'b0, 1'b1, 32'h0000_1008, 32'h0BAD_BEEF, 4'b1001);
    do_req(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);

    // Reset during a store's WAIT: no ready, array untouched.
    drive(1'b0, 1'b1, 1'b1, 32'h18, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_a = '0;
    last_b = '0;
    chk("midrst_ready", a_if.memory_ready, 128'd0);
    chk("midrst_rdata", a_if.memory_rdata, 128'd0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (a_if.memory_ready) pulses++;
    end
    chk("midrst_no_ready", pulses, 128'd0);
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    chk("midrst_word_kept", a_if.memory_rdata[95:64], 32'h0000_00A2);

    // LATENCY=0, 16-word array: top-of-array line and wrap to index 0.
    for (int i = 0; i < 16; i++) do_req(1'b1, 1'b1, 4 * i, 32'hB00 + i, 4'hF);
    do_req(1'b1, 1'b0, 32'h0000_003C, 32'h0, 4'h0);
    chk("b_top_line_const", b_if.memory_rdata, {32'hB0F, 32'hB0E, 32'hB0D, 32'hB0C});
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    chk("b_wrap_line_const", b_if.memory_rdata, {32'hB03, 32'hB02, 32'hB01, 32'hB00});
    do_req(1'b1, 1'b1, 32'h0000_0048, 32'h7700_0000, 4'b1000);
    do_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
    chk("b_wrap_store_const", b_if.memory_rdata[95:64], 32'h7700_0B02);

    // Valid dropped for one FILL cycle; the load still completes on latched values.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    repeat (4) begin @(posedge clk); #1; end
    drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("perr_after_drop", a_if.proto_err, {127'd0, exp_perr});
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    n = 5;
    while (!a_if.memory_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("perr_txn_latency", n, 128'd8);
    chk("perr_txn_rdata", a_if.memory_rdata, model_line(1'b0, 32'h10));
    $display("txn A LD-drop addr=00000010 n=%0d perr=%0b", n, a_if.proto_err);
    repeat (3) begin @(posedge clk); #1; end
    chk("perr_sticky", a_if.proto_err, {127'd0, exp_perr});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
